// File: rtl/mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle ARM-subset control unit: FSM state
// encoding, ALUControl codes, condition codes, opcode encodings, datapath
// select constants and the DP-instruction ALU decode helper.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Controller states; one instruction walks FETCH -> DECODE -> ... -> FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    // ALUControl codes.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field encodings.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Opcode encodings (instruction bits [27:26]).
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    // DP command field encodings.
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Datapath select constants.
    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Result of decoding a DP command field.
    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic       no_write;   // result is not written back
        logic       arith;      // ADD/SUB: C and V are meaningful
        logic       cmp;        // CMP: updates all four flags
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{alu_ctrl: ALU_ADD, no_write: 1'b1, arith: 1'b0, cmp: 1'b0};
        case (cmd)
            CMD_ADD: d = '{alu_ctrl: ALU_ADD, no_write: 1'b0, arith: 1'b1, cmp: 1'b0};
            CMD_SUB: d = '{alu_ctrl: ALU_SUB, no_write: 1'b0, arith: 1'b1, cmp: 1'b0};
            CMD_AND: d = '{alu_ctrl: ALU_AND, no_write: 1'b0, arith: 1'b0, cmp: 1'b0};
            CMD_ORR: d = '{alu_ctrl: ALU_ORR, no_write: 1'b0, arith: 1'b0, cmp: 1'b0};
            CMD_CMP: d = '{alu_ctrl: ALU_SUB, no_write: 1'b1, arith: 1'b1, cmp: 1'b1};
            default: d = '{alu_ctrl: ALU_ADD, no_write: 1'b1, arith: 1'b0, cmp: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_cond_unit.sv
// -----------------------------------------------------------------------------
// cond_unit
// Holds the {N,Z,C,V} flag register and evaluates the instruction condition
// against the registered flags.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (flags -> 0000)
//   cond_i         - instruction condition field
//   alu_flags_i    - {N,Z,C,V} produced by the ALU this cycle
//   flag_w_i       - [1] update N,Z ; [0] update C,V
//   flag_upd_i     - strobe: this cycle's ALU result may update the flags
//   cond_ex_o      - condition passed
// -----------------------------------------------------------------------------
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       flag_upd_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = flags_q;

    // Condition evaluation on the registered flags.
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z_s;
            COND_NE: cond_ex_o = ~z_s;
            COND_CS: cond_ex_o = c_s;
            COND_CC: cond_ex_o = ~c_s;
            COND_MI: cond_ex_o = n_s;
            COND_PL: cond_ex_o = ~n_s;
            COND_VS: cond_ex_o = v_s;
            COND_VC: cond_ex_o = ~v_s;
            COND_HI: cond_ex_o = c_s & ~z_s;
            COND_LS: cond_ex_o = ~c_s | z_s;
            COND_GE: cond_ex_o = (n_s == v_s);
            COND_LT: cond_ex_o = (n_s != v_s);
            COND_GT: cond_ex_o = ~z_s & (n_s == v_s);
            COND_LE: cond_ex_o = z_s | (n_s != v_s);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    // Next flag value: each half updates only when enabled and the condition held.
    always_comb begin
        flags_d      = flags_q;
        flags_d[3:2] = (flag_upd_i & cond_ex_o & flag_w_i[1]) ? alu_flags_i[3:2] : flags_q[3:2];
        flags_d[1:0] = (flag_upd_i & cond_ex_o & flag_w_i[0]) ? alu_flags_i[1:0] : flags_q[1:0];
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle control unit for the ARM-subset core. Sequences FETCH / DECODE /
// EXECUTE / WB, drives datapath selects and write enables, and owns the
// condition flags (via cond_unit).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   Cond, Op, Funct, Rd   - fields from the instruction register
//   ALUFlags              - {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite - write enables
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl - selects
//   instr_count           - retired-instruction counter (MC_INSTR_CNT_EN only)
// Optional feature macro: MC_INSTR_CNT_EN
// -----------------------------------------------------------------------------
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
`ifdef MC_INSTR_CNT_EN
    output logic [CNT_W-1:0] instr_count,
`endif
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl
);

    state_e     state_q, state_d;
    alu_dec_t   dec_s;
    logic [1:0] flag_w_s;
    logic       flag_upd_s;
    logic       cond_ex_s;
    logic       next_pc_s, branch_s, reg_w_s, mem_w_s, ir_write_s;

    assign dec_s = alu_decode(Funct[4:1]);

    // N,Z follow S; C,V only for arithmetic; CMP always writes all four.
    assign flag_w_s[1] = Funct[0] | dec_s.cmp;
    assign flag_w_s[0] = (Funct[0] & dec_s.arith) | dec_s.cmp;

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w_s),
        .flag_upd_i  (flag_upd_s),
        .cond_ex_o   (cond_ex_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore-decoded controls.
    always_comb begin
        state_d    = state_q;
        next_pc_s  = 1'b0;
        branch_s   = 1'b0;
        reg_w_s    = 1'b0;
        mem_w_s    = 1'b0;
        ir_write_s = 1'b0;
        flag_upd_s = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                next_pc_s  = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_B:    state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w_s   = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w_s = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = dec_s.alu_ctrl;
                flag_upd_s = 1'b1;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_s.alu_ctrl;
                flag_upd_s = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w_s   = ~dec_s.no_write;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                branch_s  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Condition-gated write enables, forced off while reset is asserted.
    always_comb begin
        PCWrite  = ~reset & (next_pc_s | (cond_ex_s & (branch_s | (reg_w_s & (Rd == 4'd15)))));
        MemWrite = ~reset & mem_w_s & cond_ex_s;
        RegWrite = ~reset & reg_w_s & cond_ex_s;
        IRWrite  = ~reset & ir_write_s;
    end

    // Register-file read selects depend only on the instruction class.
    always_comb begin
        case (Op)
            OP_MEM:  RegSrc = 2'b10;
            OP_B:    RegSrc = 2'b01;
            default: RegSrc = 2'b00;
        endcase
    end

    assign ImmSrc = Op;

`ifdef MC_INSTR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Retired-instruction counter: every return to FETCH counts, taken or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign instr_count = cnt_q;
`else
    // CNT_W only sizes the counter; keep it referenced in the counter-less build.
    logic unused_cnt_w_s;
    assign unused_cnt_w_s = (CNT_W > 0);
`endif

endmodule
